// File: rtl/gshare_predictor.sv
// gshare conditional-branch predictor with speculative global history.
// Fetch looks up the PHT with PC xor speculative history and shifts the
// predicted direction into spec_ghr. Each accepted prediction is queued in
// order. Execute resolves the oldest entry, trains its counter and shifts
// the real outcome into arch_ghr. A mispredict or a flush empties the queue
// and rebuilds spec_ghr from the resolved history.
module gshare_predictor #(
    parameter int unsigned PC_W    = 14,
    parameter int unsigned IDX_W   = 10,
    parameter int unsigned GHR_W   = 10,
    parameter int unsigned CTR_W   = 2,
    parameter int unsigned Q_DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [PC_W-1:0]                PC_F,
    input  logic                           branch_en_F,
    output logic                           BP_decision,
    output logic                           bp_ready,
    input  logic                           branch_en_EX,
    input  logic                           branch_result,
    output logic                           mispredict,
    input  logic                           flush,
    output logic [$clog2(Q_DEPTH+1)-1:0]   pending_cnt
);

    localparam int unsigned CNT_W = $clog2(Q_DEPTH + 1);
    localparam int unsigned PTR_W = $clog2(Q_DEPTH);
    localparam int unsigned PHT_N = 1 << IDX_W;
    localparam logic [CTR_W-1:0] CTR_INIT = {1'b1, {(CTR_W-1){1'b0}}};

    // Pattern history table and history registers
    logic [CTR_W-1:0]   r_pht [PHT_N];
    logic [GHR_W-1:0]   r_spec_ghr;
    logic [GHR_W-1:0]   r_arch_ghr;

    // In-flight branch queue
    logic [IDX_W-1:0]   r_q_idx [Q_DEPTH];
    logic [Q_DEPTH-1:0] r_q_pred;
    logic [PTR_W-1:0]   r_head;
    logic [PTR_W-1:0]   r_tail;
    logic [CNT_W-1:0]   r_count;

    logic [IDX_W-1:0]   w_idx;
    logic               w_pred;
    logic               w_fetch_acc;
    logic               w_resolve;
    logic [IDX_W-1:0]   w_head_idx;
    logic               w_head_pred;
    logic               w_mispredict;
    logic               w_recover;
    logic [GHR_W-1:0]   w_arch_next;
    logic [CTR_W-1:0]   w_pht_old;
    logic [CTR_W-1:0]   w_pht_new;

    // Fetch lookup, resolve detection and head-entry decode
    always_comb begin
        w_idx        = PC_F[IDX_W-1:0] ^ IDX_W'(r_spec_ghr);
        w_pred       = r_pht[w_idx][CTR_W-1];
        bp_ready     = (r_count < CNT_W'(Q_DEPTH));
        w_fetch_acc  = branch_en_F & bp_ready;
        w_resolve    = branch_en_EX & (r_count != '0);
        w_head_idx   = r_q_idx[r_head];
        w_head_pred  = r_q_pred[r_head];
        w_mispredict = w_resolve & (branch_result != w_head_pred);
        w_recover    = flush | w_mispredict;
        w_arch_next  = w_resolve ? {r_arch_ghr[GHR_W-2:0], branch_result} : r_arch_ghr;
        BP_decision  = w_fetch_acc & w_pred;
        mispredict   = w_mispredict;
        pending_cnt  = r_count;
    end

    // Saturating update of the counter belonging to the resolving branch
    always_comb begin
        w_pht_old = r_pht[w_head_idx];
        w_pht_new = w_pht_old;
        if (branch_result && (w_pht_old != '1)) begin
            w_pht_new = w_pht_old + CTR_W'(1);
        end else if (!branch_result && (w_pht_old != '0)) begin
            w_pht_new = w_pht_old - CTR_W'(1);
        end
    end

    // PHT training on resolve; all counters start weakly taken
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < PHT_N; i++) begin
                r_pht[i] <= CTR_INIT;
            end
        end else if (w_resolve) begin
            r_pht[w_head_idx] <= w_pht_new;
        end
    end

    // History registers; on a mispredict the recovery value
    // {arch_ghr, branch_result} equals the post-resolve arch_ghr, so
    // mispredict and flush share one recovery path
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_arch_ghr <= '0;
            r_spec_ghr <= '0;
        end else begin
            r_arch_ghr <= w_arch_next;
            if (w_recover) begin
                r_spec_ghr <= w_arch_next;
            end else if (w_fetch_acc) begin
                r_spec_ghr <= {r_spec_ghr[GHR_W-2:0], w_pred};
            end
        end
    end

    // In-order queue of {idx, pred}; recovery discards everything in flight
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < Q_DEPTH; i++) begin
                r_q_idx[i] <= '0;
            end
            r_q_pred <= '0;
            r_head   <= '0;
            r_tail   <= '0;
            r_count  <= '0;
        end else if (w_recover) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_fetch_acc) begin
                r_q_idx[r_tail]  <= w_idx;
                r_q_pred[r_tail] <= w_pred;
                r_tail           <= r_tail + PTR_W'(1);
            end
            if (w_resolve) begin
                r_head <= r_head + PTR_W'(1);
            end
            if (w_fetch_acc && !w_resolve) begin
                r_count <= r_count + CNT_W'(1);
            end else if (!w_fetch_acc && w_resolve) begin
                r_count <= r_count - CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_gshare_predictor.sv
// Directed bench for gshare_predictor with default parameters.
// Inputs change on the falling edge; combinational outputs are checked
// 1 ns later and registered state at the following falling edge.
module tb_gshare_predictor;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [13:0] PC_F = '0;
    logic        branch_en_F = 1'b0;
    logic        BP_decision;
    logic        bp_ready;
    logic        branch_en_EX = 1'b0;
    logic        branch_result = 1'b0;
    logic        mispredict;
    logic        flush = 1'b0;
    logic [2:0]  pending_cnt;

    int errors = 0;
    int checks = 0;

    gshare_predictor #(
        .PC_W    (14),
        .IDX_W   (10),
        .GHR_W   (10),
        .CTR_W   (2),
        .Q_DEPTH (4)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .PC_F          (PC_F),
        .branch_en_F   (branch_en_F),
        .BP_decision   (BP_decision),
        .bp_ready      (bp_ready),
        .branch_en_EX  (branch_en_EX),
        .branch_result (branch_result),
        .mispredict    (mispredict),
        .flush         (flush),
        .pending_cnt   (pending_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h required=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        branch_en_F   = 1'b0;
        branch_en_EX  = 1'b0;
        branch_result = 1'b0;
        flush         = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle();
        #2 rst = 1'b0;
        #1;
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        // ---------------- reset state ----------------
        #1 rst = 1'b0;
        #1;
        check("rst_pending", 32'(pending_cnt), 32'd0);
        check("rst_ready", 32'(bp_ready), 32'd1);
        check("rst_bp", 32'(BP_decision), 32'd0);
        check("rst_misp", 32'(mispredict), 32'd0);
        check("rst_pht", 32'(dut.r_pht[16]), 32'd2);
        @(negedge clk);
        rst = 1'b1;

        // fetch PC without branch_en_F gives no prediction
        PC_F = 14'h010;
        #1 check("nofetch_bp", 32'(BP_decision), 32'd0);

        // resolve with empty queue is ignored
        branch_en_EX = 1'b1; branch_result = 1'b0;
        #1 check("empty_res_misp", 32'(mispredict), 32'd0);
        @(negedge clk);
        idle();
        check("empty_res_arch", 32'(dut.r_arch_ghr), 32'd0);
        check("empty_res_pend", 32'(pending_cnt), 32'd0);

        // first fetch after reset: weakly taken
        branch_en_F = 1'b1; PC_F = 14'h010;
        #1 check("first_bp", 32'(BP_decision), 32'd1);
        @(negedge clk);
        idle();
        check("first_pend", 32'(pending_cnt), 32'd1);
        check("first_ready", 32'(bp_ready), 32'd1);
        check("first_spec", 32'(dut.r_spec_ghr), 32'h001);

        // ---------------- training at 0x040 ----------------
        do_reset();
        // pair 1
        branch_en_F = 1'b1; PC_F = 14'h040;
        #1 check("tr1_bp", 32'(BP_decision), 32'd1);
        @(negedge clk);
        idle(); branch_en_EX = 1'b1; branch_result = 1'b0;
        #1 check("tr1_misp", 32'(mispredict), 32'd1);
        @(negedge clk);
        idle();
        check("tr1_pht", 32'(dut.r_pht[64]), 32'd1);
        check("tr1_spec", 32'(dut.r_spec_ghr), 32'd0);
        // pair 2
        branch_en_F = 1'b1; PC_F = 14'h040;
        #1 check("tr2_bp", 32'(BP_decision), 32'd0);
        @(negedge clk);
        idle(); branch_en_EX = 1'b1; branch_result = 1'b0;
        #1 check("tr2_misp", 32'(mispredict), 32'd0);
        @(negedge clk);
        idle();
        check("tr2_pht", 32'(dut.r_pht[64]), 32'd0);
        // pair 3: counter saturates at 00
        branch_en_F = 1'b1; PC_F = 14'h040;
        #1 check("tr3_bp", 32'(BP_decision), 32'd0);
        @(negedge clk);
        idle(); branch_en_EX = 1'b1; branch_result = 1'b0;
        #1 check("tr3_misp", 32'(mispredict), 32'd0);
        @(negedge clk);
        idle();
        check("tr3_pht_sat", 32'(dut.r_pht[64]), 32'd0);
        check("tr3_pend", 32'(pending_cnt), 32'd0);

        // ---------------- queue full ----------------
        do_reset();
        // idx sequence 0x100, 0x101, 0x103, 0x107, all taken
        branch_en_F = 1'b1; PC_F = 14'h100;
        repeat (4) @(negedge clk);
        check("full_pend", 32'(pending_cnt), 32'd4);
        check("full_ready", 32'(bp_ready), 32'd0);
        check("full_spec", 32'(dut.r_spec_ghr), 32'h00F);
        #1 check("full_5th_bp", 32'(BP_decision), 32'd0);
        @(negedge clk);
        check("full_5th_pend", 32'(pending_cnt), 32'd4);
        check("full_5th_spec", 32'(dut.r_spec_ghr), 32'h00F);

        // ---------------- full-boundary resolve + fetch ----------------
        branch_en_F = 1'b1; PC_F = 14'h100;
        branch_en_EX = 1'b1; branch_result = 1'b1;
        #1;
        check("fb_bp", 32'(BP_decision), 32'd0);
        check("fb_misp", 32'(mispredict), 32'd0);
        @(negedge clk);
        idle();
        check("fb_pend", 32'(pending_cnt), 32'd3);
        check("fb_ready", 32'(bp_ready), 32'd1);
        check("fb_arch", 32'(dut.r_arch_ghr), 32'h001);
        check("fb_pht", 32'(dut.r_pht[256]), 32'd3);
        // next fetch accepted: idx = 0x100 ^ 0x00F = 0x10F
        branch_en_F = 1'b1; PC_F = 14'h100;
        #1 check("fb_next_bp", 32'(BP_decision), 32'd1);
        @(negedge clk);
        idle();
        check("fb_next_pend", 32'(pending_cnt), 32'd4);
        check("fb_next_spec", 32'(dut.r_spec_ghr), 32'h01F);

        // asynchronous reset mid-operation
        #2 rst = 1'b0;
        #1;
        check("async_pend", 32'(pending_cnt), 32'd0);
        check("async_ready", 32'(bp_ready), 32'd1);
        check("async_spec", 32'(dut.r_spec_ghr), 32'd0);
        check("async_pht", 32'(dut.r_pht[256]), 32'd2);
        @(negedge clk);
        rst = 1'b1;

        // ---------------- mispredict recovery ----------------
        branch_en_F = 1'b1; PC_F = 14'h200;
        repeat (3) @(negedge clk);
        check("mr_pend", 32'(pending_cnt), 32'd3);
        check("mr_spec", 32'(dut.r_spec_ghr), 32'h007);
        // same-cycle fetch (idx 0x207) shows lookup but is discarded
        branch_en_EX = 1'b1; branch_result = 1'b0;
        #1;
        check("mr_misp", 32'(mispredict), 32'd1);
        check("mr_bp", 32'(BP_decision), 32'd1);
        @(negedge clk);
        idle();
        check("mr_after_pend", 32'(pending_cnt), 32'd0);
        check("mr_after_spec", 32'(dut.r_spec_ghr), 32'h000);
        check("mr_after_arch", 32'(dut.r_arch_ghr), 32'h000);
        check("mr_after_pht", 32'(dut.r_pht[512]), 32'd1);

        // ---------------- flush with resolve ----------------
        do_reset();
        branch_en_F = 1'b1; PC_F = 14'h300;
        repeat (2) @(negedge clk);
        check("fl_pend", 32'(pending_cnt), 32'd2);
        flush = 1'b1; branch_en_EX = 1'b1; branch_result = 1'b1;
        #1 check("fl_misp", 32'(mispredict), 32'd0);
        @(negedge clk);
        idle();
        check("fl_pend_after", 32'(pending_cnt), 32'd0);
        check("fl_arch", 32'(dut.r_arch_ghr), 32'h001);
        check("fl_spec", 32'(dut.r_spec_ghr), 32'h001);
        check("fl_pht", 32'(dut.r_pht[768]), 32'd3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
